// File: rtl/tc_bcd_display_if.sv
// Value-in / display-out bundle for tc_bcd_display.
`timescale 1ns/1ps
interface tc_bcd_display_if #(
   parameter int unsigned BIT_WIDTH = 16,
   parameter int unsigned DIGITS    = 5
);
   logic                   in_valid;
   logic [BIT_WIDTH-1:0]   in_value;
   logic                   busy;
   logic [4*DIGITS-1:0]    bcd;
   logic [6:0]             seg;
   logic [DIGITS-1:0]      an;

   modport master (
      output in_valid, in_value,
      input  busy, bcd, seg, an
   );

   modport slave (
      input  in_valid, in_value,
      output busy, bcd, seg, an
   );
endinterface

// File: rtl/tc_bcd_display.sv
// Samples a binary register value, converts it to BCD by sequential double-dabble,
// and scans the result onto a multiplexed 7-segment display with leading-zero blanking.
`timescale 1ns/1ps
module tc_bcd_display #(
   parameter int unsigned BIT_WIDTH = 16,
   parameter int unsigned DIGITS    = 5,
   parameter int unsigned SCAN_DIV  = 50000
) (
   input logic          clk,
   input logic          rst,
   tc_bcd_display_if.slave bus
);

   localparam int unsigned BCD_W  = 4 * DIGITS;
   localparam int unsigned CNT_W  = $clog2(BIT_WIDTH + 1);
   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

   state_t               state;
   logic [BIT_WIDTH-1:0] sh;
   logic [BCD_W-1:0]     acc;
   logic [BCD_W-1:0]     acc_adj;
   logic [CNT_W-1:0]     step;
   logic                 busy;
   logic [BCD_W-1:0]     bcd;

   logic [SCAN_W-1:0]    presc;
   logic [IDX_W-1:0]     idx;
   logic [DIGITS-1:0]    an;
   logic [IDX_W-1:0]     msd;
   logic [3:0]           cur;
   logic [6:0]           seg;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h40;
      endcase
   endfunction

   // Add-3 correction applied to every nibble before each shift
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (acc[i*4 +: 4] >= 4'd5)
            acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         bcd   <= '0;
         sh    <= '0;
         acc   <= '0;
         step  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sh    <= bus.in_value;
                  acc   <= '0;
                  step  <= '0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               {acc, sh} <= {acc_adj[BCD_W-2:0], sh, 1'b0};
               step      <= step + CNT_W'(1);
               if (step == CNT_W'(BIT_WIDTH - 1))
                  state <= LATCH;
            end
            LATCH: begin
               bcd   <= acc;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Free-running digit scanner; an is kept one-hot alongside idx
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
         an    <= DIGITS'(1);
      end else if (presc == SCAN_W'(SCAN_DIV - 1)) begin
         presc <= '0;
         if (idx == IDX_W'(DIGITS - 1)) begin
            idx <= '0;
            an  <= DIGITS'(1);
         end else begin
            idx <= idx + IDX_W'(1);
            an  <= an << 1;
         end
      end else begin
         presc <= presc + SCAN_W'(1);
      end
   end

   // Digits above the most significant nonzero nibble are blanked; digit 0 never is
   always_comb begin
      cur = 4'd0;
      msd = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (IDX_W'(i) == idx)
            cur = bcd[i*4 +: 4];
         if (bcd[i*4 +: 4] != 4'd0)
            msd = IDX_W'(i);
      end
      seg = (idx > msd) ? 7'h00 : seg_decode(cur);
   end

   assign bus.busy = busy;
   assign bus.bcd  = bcd;
   assign bus.seg  = seg;
   assign bus.an   = an;

endmodule

// File: doc/tc_bcd_display.md
Name: tc_bcd_display

Overview:
- Downstream consumer of the counter's register stage.
- Samples the register's binary output when the register is loading, converts it to BCD with a sequential double-dabble engine, and drives a time-multiplexed common-anode-agnostic 7-segment display (active-high segments and digit enables).
- Sits between the counter datapath and the board's display pins; one instance per displayed register.

Parameters:
BIT_WIDTH, 16, width of the binary input value
DIGITS, 5, number of display digits; must satisfy 10^DIGITS > 2^BIT_WIDTH
SCAN_DIV, 50000, clk cycles each digit stays enabled

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_value is meaningful this cycle (wired to the register's load)
in_value  input  BIT_WIDTH  binary value from the register output
busy  output  1  conversion in progress; in_valid ignored while high
bcd  output  4*DIGITS  latched BCD result, nibble 0 = units
seg  output  7  segment drive, bit0=a through bit6=g, active-high
an  output  DIGITS  one-hot digit enable, bit0 = units, active-high

Behaviour:
- Reset: all of the following take effect on the first clk edge with rst=1.
  - State IDLE, busy=0, bcd=0.
  - Scan prescaler=0, digit index=0, so an=1 and seg=0x3F ("0").
  - rst overrides every other input.
  - rst during conversion aborts it and clears bcd.
- Converter FSM, states IDLE, CONV, LATCH:
  - IDLE: if in_valid=1 at edge E0, capture in_value into shift register, clear BCD accumulator, clear step counter, go to CONV, busy=1. If in_valid=0, stay in IDLE.
  - CONV: each edge, first add 3 to every accumulator nibble >=5, then shift {accumulator, shift register} left by 1, and increment the step counter. The edge performing the BIT_WIDTH-th shift (E_BIT_WIDTH) moves to LATCH.
  - LATCH: at edge E_{BIT_WIDTH+1}, bcd<=accumulator, busy=0, go to IDLE.
- Timing:
  - Latency from capture edge to bcd update is BIT_WIDTH+1 edges.
  - busy is high for BIT_WIDTH+1 cycles.
  - Minimum capture-to-capture period is BIT_WIDTH+2 cycles.
  - in_valid in CONV or LATCH is dropped (no queueing).
  - in_valid held high continuously yields a capture on every first IDLE cycle.
- Value zero converts normally, giving bcd=0.
- The maximum input 2^BIT_WIDTH-1 must convert exactly with no truncation.
- bcd holds its value between conversions.
- Scanner, free-running and independent of the FSM:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the wrap edge, the digit index advances; DIGITS-1 wraps to 0.
  - an = one-hot(index).
  - seg is combinational from the registered index and bcd, so a bcd change is visible on seg in the same cycle.
- Decode (hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; nibble 10–15, which is unreachable, decodes to 40 (dash).
- Leading-zero blanking:
  - A digit above the most significant nonzero nibble outputs seg=0x00, while an still asserts.
  - Digit 0 is never blanked.

Test Plan:
- Reset: hold rst 2 cycles, release -> busy=0, bcd=0x00000, an=5'b00001, seg=0x3F; then SCAN_DIV edges later an=5'b00010, seg=0x00 (blanked).
- Single conversion: in_value=1234, in_valid pulse at E0 -> busy=1 for 17 cycles, bcd=0x01234 exactly at E17, busy=0 after E17; no earlier bcd change.
- Max/zero: in_value=65535 -> bcd=0x65535; in_value=0 -> bcd=0x00000; back-to-back captures 18 cycles apart both land correctly.
- Drop while busy: in_valid held high, in_value=100 at E0 then 200 at E1..E17, 300 from E18 -> bcd=0x00100 at E17, second capture at E18 takes 300, giving bcd=0x00300 at E35; value 200 is never seen.
- Scan/blanking with SCAN_DIV=4: bcd=0x00507 -> an walks 00001,00010,00100,01000,10000 every 4 cycles and wraps; seg=0x07,0x3F,0x6D,0x00,0x00 respectively.
- Reset mid-operation: rst at E8 of a conversion of 999 -> busy=0 and bcd=0 after that edge; a new in_valid of 42 after release gives bcd=0x00042 17 edges after capture.
